// File: rtl/pattern_divider.sv
// pattern_divider: sequential restoring divider.
// Divides a 2*dw-bit dividend by a dw-bit divisor and produces one quotient
// bit per cycle, MSB first. The result is flagged when the quotient equals
// the compile-time constant `pattern`. The block accepts one operation at a
// time and uses valid/ready on both the input and the output side.
module pattern_divider #(
  parameter int unsigned     dw      = 8,
  parameter logic [dw-1:0]   pattern = 8'd18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*dw-1:0]   dividend,
  input  logic [dw-1:0]     divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [dw-1:0]     quotient,
  output logic [dw-1:0]     remainder,
  output logic              overflow,
  output logic              pattern_detected
);

  localparam int unsigned CW = $clog2(dw + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [dw-1:0]   divisor_r, divisor_s;
  logic [dw-1:0]   low_r, low_s;        // dividend low half, consumed MSB first
  logic [dw-1:0]   rem_r, rem_s;        // partial remainder, always < divisor
  logic [dw-1:0]   quo_r, quo_s;        // quotient shift register
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            ovf_pend_r, ovf_pend_s;
  logic            in_ready_r;
  logic            out_valid_r;
  logic [dw-1:0]   quotient_r, quotient_s;
  logic [dw-1:0]   remainder_r, remainder_s;
  logic            overflow_r, overflow_s;
  logic            pattern_detected_r, pattern_detected_s;

  // One restoring step: the shifted remainder needs dw+1 bits so the compare
  // is correct when the divisor has its MSB set.
  logic [dw:0]     shift_s;
  logic [dw:0]     step_rem_s;
  logic            ge_s;
  logic [dw-1:0]   step_quo_s;

  // Datapath for a single quotient bit.
  always_comb begin
    shift_s    = {rem_r, low_r[dw-1]};
    ge_s       = (shift_s >= {1'b0, divisor_r});
    step_rem_s = ge_s ? (shift_s - {1'b0, divisor_r}) : shift_s;
    step_quo_s = dw'({quo_r, ge_s});
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE controller.
  always_comb begin
    state_s            = state_r;
    divisor_s          = divisor_r;
    low_s              = low_r;
    rem_s              = rem_r;
    quo_s              = quo_r;
    cnt_s              = cnt_r;
    ovf_pend_s         = ovf_pend_r;
    quotient_s         = quotient_r;
    remainder_s        = remainder_r;
    overflow_s         = overflow_r;
    pattern_detected_s = pattern_detected_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          divisor_s  = divisor;
          low_s      = dividend[dw-1:0];
          rem_s      = dividend[2*dw-1:dw];
          quo_s      = {dw{1'b0}};
          cnt_s      = CW'(dw);
          // The overflow decision is taken here but resolved on the next
          // edge, so an overflow result appears one edge after acceptance.
          ovf_pend_s = (divisor == {dw{1'b0}}) ||
                       (dividend[2*dw-1:dw] >= divisor);
          state_s    = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (ovf_pend_r) begin
          ovf_pend_s         = 1'b0;
          quotient_s         = {dw{1'b1}};
          remainder_s        = {dw{1'b0}};
          overflow_s         = 1'b1;
          pattern_detected_s = 1'b0;
          state_s            = DONE;
        end else begin
          rem_s = dw'(step_rem_s);
          quo_s = step_quo_s;
          low_s = dw'({low_r, 1'b0});
          cnt_s = cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            quotient_s         = step_quo_s;
            remainder_s        = dw'(step_rem_s);
            overflow_s         = 1'b0;
            pattern_detected_s = (step_quo_s == pattern);
            state_s            = DONE;
          end else begin
            state_s = RUN;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; rst abandons any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r            <= IDLE;
      divisor_r          <= {dw{1'b0}};
      low_r              <= {dw{1'b0}};
      rem_r              <= {dw{1'b0}};
      quo_r              <= {dw{1'b0}};
      cnt_r              <= {CW{1'b0}};
      ovf_pend_r         <= 1'b0;
      in_ready_r         <= 1'b1;
      out_valid_r        <= 1'b0;
      quotient_r         <= {dw{1'b0}};
      remainder_r        <= {dw{1'b0}};
      overflow_r         <= 1'b0;
      pattern_detected_r <= 1'b0;
    end else begin
      state_r            <= state_s;
      divisor_r          <= divisor_s;
      low_r              <= low_s;
      rem_r              <= rem_s;
      quo_r              <= quo_s;
      cnt_r              <= cnt_s;
      ovf_pend_r         <= ovf_pend_s;
      in_ready_r         <= (state_s == IDLE);
      out_valid_r        <= (state_s == DONE);
      quotient_r         <= quotient_s;
      remainder_r        <= remainder_s;
      overflow_r         <= overflow_s;
      pattern_detected_r <= pattern_detected_s;
    end
  end

  assign in_ready         = in_ready_r;
  assign out_valid        = out_valid_r;
  assign quotient         = quotient_r;
  assign remainder        = remainder_r;
  assign overflow         = overflow_r;
  assign pattern_detected = pattern_detected_r;

endmodule

// File: tb/tb_pattern_divider.sv
// Scoreboard bench for pattern_divider: stimulus pushes hand-computed
// results into a queue, a monitor pops and compares on each output handshake.
module tb_pattern_divider;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        overflow;
  logic        pattern_detected;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       ovf;
    logic       pd;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  pattern_divider #(.dw(8), .pattern(8'd18)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .dividend         (dividend),
    .divisor          (divisor),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .quotient         (quotient),
    .remainder        (remainder),
    .overflow         (overflow),
    .pattern_detected (pattern_detected)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted result against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got q=%0d with no expected result", quotient);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("quotient", {24'd0, quotient}, {24'd0, e.q});
        check("remainder", {24'd0, remainder}, {24'd0, e.r});
        check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        check("pattern_detected", {31'd0, pattern_detected}, {31'd0, e.pd});
      end
    end
  end

  // Present one operation and let it be accepted; optionally score it.
  task automatic start_op(input logic [15:0] dvd, input logic [7:0] dvs,
                          input logic push, input exp_t e);
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges from acceptance until out_valid, bounded.
  task automatic wait_valid(input int exp_lat);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, exp_lat);
  endtask

  // Full operation with out_ready already high.
  task automatic do_op(input logic [15:0] dvd, input logic [7:0] dvs,
                       input logic [7:0] q, input logic [7:0] r,
                       input logic ovf, input logic pd, input int lat);
    exp_t e;
    e = '{q: q, r: r, ovf: ovf, pd: pd};
    start_op(dvd, dvs, 1'b1, e);
    wait_valid(lat);
    @(posedge clk); #1;
    check("out_valid_after_handshake", {31'd0, out_valid}, 32'd0);
    check("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_quotient"}, {24'd0, quotient}, 32'd0);
    check({tag, "_remainder"}, {24'd0, remainder}, 32'd0);
    check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    check({tag, "_pattern_detected"}, {31'd0, pattern_detected}, 32'd0);
  endtask

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Directed stimulus.
  initial begin
    exp_t e;
    rst       = 1'b1;
    in_valid  = 1'b0;
    dividend  = 16'd0;
    divisor   = 8'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");

    // Table of directed operations.
    do_op(16'd324,  8'd18,  8'd18,  8'd0,   1'b0, 1'b1, 8);
    do_op(16'd1000, 8'd7,   8'd142, 8'd6,   1'b0, 1'b0, 8);
    do_op(16'hFEFF, 8'hFF,  8'd255, 8'd254, 1'b0, 1'b0, 8);
    do_op(16'h0000, 8'h01,  8'd0,   8'd0,   1'b0, 1'b0, 8);
    do_op(16'd500,  8'd0,   8'hFF,  8'd0,   1'b1, 1'b0, 1);
    do_op(16'h1234, 8'h12,  8'hFF,  8'd0,   1'b1, 1'b0, 1);

    // Backpressure with ignored input during DONE.
    out_ready = 1'b0;
    e = '{q: 8'd142, r: 8'd6, ovf: 1'b0, pd: 1'b0};
    start_op(16'd1000, 8'd7, 1'b1, e);
    wait_valid(8);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      dividend = 16'd256;
      divisor  = 8'd3;
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_quotient", {24'd0, quotient}, 32'd142);
      check("bp_remainder", {24'd0, remainder}, 32'd6);
      @(posedge clk); #1;
    end
    check("bp_quotient_end", {24'd0, quotient}, 32'd142);
    out_ready = 1'b1;
    exp_q.push_back('{q: 8'd85, r: 8'd1, ovf: 1'b0, pd: 1'b0});
    @(posedge clk); #1;
    check("bp_in_ready_after_release", {31'd0, in_ready}, 32'd1);
    check("bp_out_valid_after_release", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(8);
    @(posedge clk); #1;

    // Reset in the middle of RUN abandons 324/18.
    e = '{q: 8'd0, r: 8'd0, ovf: 1'b0, pd: 1'b0};
    start_op(16'd324, 8'd18, 1'b0, e);
    repeat (3) @(posedge clk);
    #1;
    check("mid_run_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("mid_run_reset");
    repeat (10) begin
      @(posedge clk); #1;
      check("no_result_after_reset", {31'd0, out_valid}, 32'd0);
    end
    do_op(16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 1'b0, 8);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
